// File: rtl/output_pulse_gen.sv
// Single-shot output pulse scheduler: programmable delay, active width and
// enforced off-time, with registered rise/fall/overrun strobes.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  IDLE   | waiting for start; out low, busy low
//  DELAY  | counting down the latched start-to-assert delay
//  ACTIVE | out high, counting down the latched width
//  GAP    | out low, enforcing the latched minimum off-time
module output_pulse_gen #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] delay,
  input  logic [WIDTH-1:0] width,
  input  logic [WIDTH-1:0] gap,
  output logic             out,
  output logic             busy,
  output logic             rise,
  output logic             fall,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    ACTIVE = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] width_lat, width_lat_nxt;
  logic [WIDTH-1:0] gap_lat, gap_lat_nxt;
  logic             out_nxt, busy_nxt, rise_nxt, fall_nxt, overrun_nxt;
  logic             cnt_zero;

  assign cnt_zero = (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      width_lat <= '0;
      gap_lat   <= '0;
      out       <= 1'b0;
      busy      <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      width_lat <= width_lat_nxt;
      gap_lat   <= gap_lat_nxt;
      out       <= out_nxt;
      busy      <= busy_nxt;
      rise      <= rise_nxt;
      fall      <= fall_nxt;
      overrun   <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    width_lat_nxt = width_lat;
    gap_lat_nxt   = gap_lat;
    case (state)
      IDLE: begin
        if (start && ena && !abort) begin
          state_nxt     = DELAY;
          cnt_nxt       = delay;
          width_lat_nxt = width;
          gap_lat_nxt   = gap;
        end
      end
      DELAY: begin
        if (abort) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (ena) begin
          if (!cnt_zero) begin
            cnt_nxt = cnt - ONE;
          end else if (width_lat != '0) begin
            state_nxt = ACTIVE;
            cnt_nxt   = width_lat - ONE;
          end else if (gap_lat != '0) begin
            state_nxt = GAP;
            cnt_nxt   = gap_lat - ONE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      ACTIVE: begin
        // abort still routes through the off-time so the pin never re-fires early
        if (abort || (ena && cnt_zero)) begin
          if (gap_lat != '0) begin
            state_nxt = GAP;
            cnt_nxt   = gap_lat - ONE;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end else if (ena) begin
          cnt_nxt = cnt - ONE;
        end
      end
      GAP: begin
        if (ena) begin
          if (!cnt_zero) begin
            cnt_nxt = cnt - ONE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land on the same edge as the transition.
  always_comb begin
    out_nxt     = (state_nxt == ACTIVE);
    busy_nxt    = (state_nxt != IDLE);
    rise_nxt    = (state != ACTIVE) && (state_nxt == ACTIVE);
    fall_nxt    = (state == ACTIVE) && (state_nxt != ACTIVE);
    overrun_nxt = start && ena && (state != IDLE);
  end

endmodule

// File: tb/tb_output_pulse_gen.sv
// Directed bench for output_pulse_gen: stimulus pushes expected strobe/idle
// events with their cycle numbers; a negedge monitor pops and compares them.
module tb_output_pulse_gen;

  localparam int WIDTH = 16;
  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_OVR  = 2;
  localparam int EV_IDLE = 3;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ena = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] delay = '0;
  logic [WIDTH-1:0] width = '0;
  logic [WIDTH-1:0] gap = '0;
  logic             out, busy, rise, fall, overrun;

  int  cyc = 0;
  int  e0 = 0;
  int  checks = 0;
  int  failures = 0;
  logic prev_busy = 1'b0;
  ev_t sb[$];

  output_pulse_gen #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .abort(abort),
    .delay(delay), .width(width), .gap(gap),
    .out(out), .busy(busy), .rise(rise), .fall(fall), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(int k);
    case (k)
      EV_RISE: return "rise";
      EV_FALL: return "fall";
      EV_OVR:  return "overrun";
      default: return "idle";
    endcase
  endfunction

  task automatic check_ev(input int kind, input logic lvl, input logic lvl_exp);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event got %s at cycle %0d, required no event", kname(kind), cyc - e0);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.cyc != cyc || lvl != lvl_exp) begin
        failures++;
        $display("FAIL event got %s at E%0d out=%0b, required %s at E%0d out=%0b",
                 kname(kind), cyc - e0, lvl, kname(e.kind), e.cyc - e0, lvl_exp);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rise) check_ev(EV_RISE, out, 1'b1);
    if (fall) check_ev(EV_FALL, out, 1'b0);
    if (overrun) check_ev(EV_OVR, 1'b0, 1'b0);
    if (prev_busy && !busy) check_ev(EV_IDLE, 1'b0, 1'b0);
    prev_busy = busy;
  end

  task automatic check_val(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got %0b required %0b", name, act, req);
    end
  endtask

  task automatic expect_ev(input int kind, input int k);
    ev_t e;
    e.kind = kind;
    e.cyc  = e0 + k;
    sb.push_back(e);
  endtask

  task automatic launch(input int d, input int w, input int g);
    @(posedge clk); #1;
    delay = WIDTH'(d);
    width = WIDTH'(w);
    gap   = WIDTH'(g);
    start = 1'b1;
    @(posedge clk); #1;
    e0    = cyc;
    start = 1'b0;
  endtask

  task automatic wait_rel(input int k);
    while (cyc < e0 + k) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic finish_case(input string name);
    int n = 0;
    while (busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL %s_timeout got busy=1 after %0d cycles, required busy=0", name, n);
    end
    @(posedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_missing got %0d events pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_out", out, 1'b0);
    check_val("reset_busy", busy, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("idle_out", out, 1'b0);
    check_val("idle_busy", busy, 1'b0);
    check_val("idle_strobes", rise | fall | overrun, 1'b0);

    // case 1: D=3 W=4 G=2
    launch(3, 4, 2);
    expect_ev(EV_RISE, 4); expect_ev(EV_FALL, 8); expect_ev(EV_IDLE, 10);
    check_val("c1_busy_e0", busy, 1'b1);
    wait_rel(3);
    check_val("c1_out_e3", out, 1'b0);
    wait_rel(7);
    check_val("c1_out_e7", out, 1'b1);
    finish_case("c1");

    // case 2: D=0 W=1 G=0
    launch(0, 1, 0);
    expect_ev(EV_RISE, 1); expect_ev(EV_FALL, 2); expect_ev(EV_IDLE, 2);
    finish_case("c2");

    // case 3: D=2 W=0 G=3 (no pulse)
    launch(2, 0, 3);
    expect_ev(EV_IDLE, 6);
    wait_rel(5);
    check_val("c3_busy_e5", busy, 1'b1);
    finish_case("c3");

    // all-zero request returns to IDLE at E1
    launch(0, 0, 0);
    expect_ev(EV_IDLE, 1);
    finish_case("zero");

    // case 4: overrun
    launch(3, 4, 2);
    expect_ev(EV_RISE, 4); expect_ev(EV_OVR, 6); expect_ev(EV_FALL, 8); expect_ev(EV_IDLE, 10);
    wait_rel(5); start = 1'b1;
    wait_rel(6); start = 1'b0;
    finish_case("c4");

    // case 5a: abort in ACTIVE
    launch(3, 4, 2);
    expect_ev(EV_RISE, 4); expect_ev(EV_FALL, 6); expect_ev(EV_IDLE, 8);
    wait_rel(5); abort = 1'b1;
    wait_rel(6); abort = 1'b0;
    check_val("c5a_out_e6", out, 1'b0);
    finish_case("c5a");

    // case 5b: abort in DELAY
    launch(3, 4, 2);
    expect_ev(EV_IDLE, 3);
    wait_rel(2); abort = 1'b1;
    wait_rel(3); abort = 1'b0;
    finish_case("c5b");

    // case 6a: ena freeze during ACTIVE
    launch(3, 4, 2);
    expect_ev(EV_RISE, 4); expect_ev(EV_FALL, 11); expect_ev(EV_IDLE, 13);
    wait_rel(5); ena = 1'b0;
    wait_rel(8); ena = 1'b1;
    check_val("c6a_out_e8", out, 1'b1);
    finish_case("c6a");

    // case 6b: async reset mid-pulse, then a normal pulse
    launch(3, 4, 2);
    expect_ev(EV_RISE, 4); expect_ev(EV_IDLE, 6);
    wait_rel(6);
    check_val("c6b_out_before_rst", out, 1'b1);
    rst = 1'b0;
    #1;
    check_val("c6b_out_async", out, 1'b0);
    check_val("c6b_busy_async", busy, 1'b0);
    check_val("c6b_no_fall", fall, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    finish_case("c6b");
    launch(3, 4, 2);
    expect_ev(EV_RISE, 4); expect_ev(EV_FALL, 8); expect_ev(EV_IDLE, 10);
    finish_case("c6b_after");

    // start with ena=0 in IDLE is ignored, no overrun
    @(posedge clk); #1;
    ena = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ena = 1'b1;
    @(posedge clk); #1;
    check_val("ena0_start_busy", busy, 1'b0);

    // abort with start in IDLE drops the request
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check_val("abort_start_busy", busy, 1'b0);
    check_val("abort_start_out", out, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL final_pending got %0d events pending, required 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
